controle_lampada: RTL and testbench

Lamp controller that sits directly downstream of the push-button classifier in the automatic lighting design. It consumes that stage's one-cycle short-press (`B`) and long-press (`A`) pulses, plus a raw presence-sensor input, and drives the lamp. Long press toggles between automatic and manual mode. Short press toggles the lamp in manual mode. In automatic mode the lamp follows a filtered presence signal and switches off after a programmable no-presence timeout.

---
 rtl/controle_lampada_if.sv | 25 ++
 rtl/controle_lampada.sv | 115 +++++++++++
 tb/tb_controle_lampada.sv | 139 +++++++++++++
 3 files changed

// File: rtl/controle_lampada_if.sv
// Button/sensor/lamp signal bundle between the push-button stage, the
// presence sensor and the lamp controller.
interface controle_lampada_if;
    logic A;
    logic B;
    logic infravermelho;
    logic lampada;
    logic modo_manual;

    modport master (
        output A,
        output B,
        output infravermelho,
        input  lampada,
        input  modo_manual
    );

    modport slave (
        input  A,
        input  B,
        input  infravermelho,
        output lampada,
        output modo_manual
    );
endinterface

// File: rtl/controle_lampada.sv
// Lamp controller: long press toggles auto/manual mode, short press toggles the
// lamp in manual mode, automatic mode follows filtered presence with a timeout.
//
// state      | meaning
// AUTO_OFF   | automatic mode, lamp off, waiting for presence
// AUTO_ON    | automatic mode, lamp on, counting no-presence cycles
// MANUAL_OFF | manual mode, lamp off
// MANUAL_ON  | manual mode, lamp on
module controle_lampada #(
    parameter int unsigned AUTO_SHUTOFF_T  = 30000,
    parameter int unsigned PRESENCE_FILTER = 3
) (
    input  logic               clk,
    input  logic               rst,
    controle_lampada_if.slave  bus
);

    typedef enum logic [1:0] {
        AUTO_OFF   = 2'b00,
        AUTO_ON    = 2'b01,
        MANUAL_OFF = 2'b10,
        MANUAL_ON  = 2'b11
    } state_t;

    localparam logic [15:0] SHUT_LAST = 16'(AUTO_SHUTOFF_T - 1);
    localparam logic [7:0]  FILT_MAX  = 8'(PRESENCE_FILTER);

    state_t      state_q, state_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic [7:0]  filt_cnt_q, filt_cnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic        presenca;

    assign presenca = (filt_cnt_q == FILT_MAX);

    always_comb begin
        s1_d       = bus.infravermelho;
        s2_d       = s1_q;
        filt_cnt_d = filt_cnt_q;
        if (!s2_q) begin
            filt_cnt_d = 8'd0;
        end else if (filt_cnt_q != FILT_MAX) begin
            filt_cnt_d = filt_cnt_q + 8'd1;
        end
    end

    // A is tested first in every state so a simultaneous B is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            AUTO_OFF: begin
                if (bus.A) begin
                    state_d = MANUAL_OFF;
                end else if (presenca) begin
                    state_d = AUTO_ON;
                    cnt_d   = 16'd0;
                end
            end
            AUTO_ON: begin
                if (bus.A) begin
                    state_d = MANUAL_ON;
                end else if (presenca) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == SHUT_LAST) begin
                    state_d = AUTO_OFF;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            MANUAL_OFF: begin
                if (bus.A) begin
                    state_d = AUTO_OFF;
                end else if (bus.B) begin
                    state_d = MANUAL_ON;
                end
            end
            MANUAL_ON: begin
                if (bus.A) begin
                    state_d = AUTO_ON;
                    cnt_d   = 16'd0;
                end else if (bus.B) begin
                    state_d = MANUAL_OFF;
                end
            end
            default: begin
                state_d = AUTO_OFF;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= AUTO_OFF;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            filt_cnt_q <= 8'd0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            filt_cnt_q <= filt_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs are a pure decode of the state register.
    assign bus.lampada     = (state_q == AUTO_ON) || (state_q == MANUAL_ON);
    assign bus.modo_manual = (state_q == MANUAL_OFF) || (state_q == MANUAL_ON);

endmodule

// File: tb/tb_controle_lampada.sv
// Directed bench for controle_lampada with AUTO_SHUTOFF_T=10, PRESENCE_FILTER=3.
module tb_controle_lampada;
    localparam int T  = 10;
    localparam int PF = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    controle_lampada_if bus ();

    controle_lampada #(
        .AUTO_SHUTOFF_T  (T),
        .PRESENCE_FILTER (PF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic a;
        logic b;
        logic ir;
        logic lamp;
        logic man;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic a, input logic b, input logic ir,
                       input logic lamp, input logic man, input int n);
        vec_t v;
        v = '{rst: r, a: a, b: b, ir: ir, lamp: lamp, man: man};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Entered at a negedge: drive, let one rising edge pass, check at next negedge.
    task automatic step(input logic r, input logic a, input logic b, input logic ir,
                        input logic lamp, input logic man, input string name);
        rst               = r;
        bus.A             = a;
        bus.B             = b;
        bus.infravermelho = ir;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.lampada !== lamp || bus.modo_manual !== man) begin
            n_fail++;
            $display("FAIL %s: lampada=%b modo_manual=%b, expected lampada=%b modo_manual=%b",
                     name, bus.lampada, bus.modo_manual, lamp, man);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        bus.A             = 1'b0;
        bus.B             = 1'b0;
        bus.infravermelho = 1'b0;

        // reset
        add(1, 0, 0, 0, 0, 0, 2);
        // glitch: high 2, low 1, high 2, low
        add(0, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 5);
        // manual control with sensor activity
        add(0, 1, 0, 1, 0, 1, 1);
        add(0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 0, 1, 1, 1, 3);
        add(0, 0, 1, 1, 0, 1, 1);
        add(0, 0, 0, 1, 0, 1, 3);
        add(0, 0, 0, 0, 0, 1, 5);
        // A and B together: only the mode toggles
        add(0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 2);
        // reset then presence: lamp after edge k+5
        add(1, 0, 0, 0, 0, 0, 2);
        add(0, 0, 0, 1, 0, 0, 5);
        add(0, 0, 0, 1, 1, 0, 2);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].ir,
                 vecs[i].lamp, vecs[i].man, $sformatf("vec%0d", i));
        end

        // timeout: presence drops 3 edges later, lamp falls on the T-th no-presence edge
        for (int i = 1; i <= 3 + T; i++)
            step(0, 0, 0, 0, (i < 3 + T), 0, $sformatf("timeout_e%0d", i));
        step(0, 0, 0, 0, 0, 0, "timeout_after");

        // back on, then presence returns before the shutoff
        for (int i = 1; i <= 6; i++)
            step(0, 0, 0, 1, (i == 6), 0, $sformatf("reon_e%0d", i));
        for (int i = 1; i <= 6; i++)
            step(0, 0, 0, 0, 1, 0, $sformatf("cancel_drop_e%0d", i));
        for (int i = 1; i <= 8; i++)
            step(0, 0, 0, 1, 1, 0, $sformatf("cancel_back_e%0d", i));
        // counter restarted: full window again
        for (int i = 1; i <= 3 + T; i++)
            step(0, 0, 0, 0, (i < 3 + T), 0, $sformatf("restart_e%0d", i));

        // mode return from MANUAL_ON with no presence
        step(0, 1, 0, 0, 0, 1, "ret_A");
        step(0, 0, 1, 0, 1, 1, "ret_B");
        step(0, 1, 0, 0, 1, 0, "ret_A_auto_on");
        for (int i = 1; i <= T; i++)
            step(0, 0, 0, 0, (i < T), 0, $sformatf("ret_timeout_e%0d", i));
        step(0, 1, 1, 0, 0, 1, "auto_off_AB");
        step(0, 1, 0, 0, 0, 0, "manual_off_A");

        // reset mid-timeout at cnt=5, released with sensor already high
        for (int i = 1; i <= 6; i++)
            step(0, 0, 0, 1, (i == 6), 0, $sformatf("mid_on_e%0d", i));
        for (int i = 1; i <= 8; i++)
            step(0, 0, 0, 0, 1, 0, $sformatf("mid_count_e%0d", i));
        step(1, 0, 0, 1, 0, 0, "mid_reset");
        for (int i = 1; i <= 6; i++)
            step(0, 0, 0, 1, (i == 6), 0, $sformatf("post_reset_e%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
